// File: rtl/hazard_ctrl.sv
// hazard_ctrl: shadow scoreboard of the E/M/W stages for the five-stage pipe.
// Drives every forwarding-mux select plus the F/D stall / E bubble decision.
// Optional build macro HAZARD_MD_STALL_EN: hold mult/div instructions in D
// while the mult/div unit is busy or being started from E.
module hazard_ctrl #(
   parameter int TNEW_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        d_rs,
   input  logic [4:0]        d_rt,
   input  logic [TNEW_W-1:0] d_tuse_rs,
   input  logic [TNEW_W-1:0] d_tuse_rt,
   input  logic [4:0]        d_dst,
   input  logic [TNEW_W-1:0] d_tnew,
   input  logic              d_is_md,
   input  logic              md_busy,
   input  logic              md_start_e,
   input  logic              flush,
   output logic              stall,
   output logic [1:0]        fwd_rs_d,
   output logic [1:0]        fwd_rt_d,
   output logic [1:0]        fwd_rs_e,
   output logic [1:0]        fwd_rt_e
);

   // All-ones Tuse marks an operand the instruction never reads.
   localparam logic [TNEW_W-1:0] TUSE_NONE = '1;
   localparam logic [TNEW_W-1:0] TNEW_ONE  = TNEW_W'(1);

   logic [4:0]        e_dst, e_rs, e_rt, m_dst, w_dst;
   logic [TNEW_W-1:0] e_tnew, m_tnew;
   logic              haz_rs, haz_rt, md_stall;

   // Scoreboard advance: reset, then flush, then stall bubble, then normal shift.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         e_dst  <= '0;
         e_tnew <= '0;
         e_rs   <= '0;
         e_rt   <= '0;
         m_dst  <= '0;
         m_tnew <= '0;
         w_dst  <= '0;
      end else begin
         if (stall) begin
            e_dst  <= '0;
            e_tnew <= '0;
            e_rs   <= '0;
            e_rt   <= '0;
         end else begin
            e_dst  <= d_dst;
            e_tnew <= d_tnew;
            e_rs   <= d_rs;
            e_rt   <= d_rt;
         end
         m_dst  <= e_dst;
         m_tnew <= (e_tnew == '0) ? '0 : e_tnew - TNEW_ONE;
         w_dst  <= m_dst;
      end
   end

   // Data hazards: a producer in E or M will not be ready by the time D needs it.
   always_comb begin
      haz_rs = 1'b0;
      haz_rt = 1'b0;
      if (d_rs != 5'd0 && d_tuse_rs != TUSE_NONE)
         haz_rs = (e_dst == d_rs && e_tnew > d_tuse_rs) ||
                  (m_dst == d_rs && m_tnew > d_tuse_rs);
      if (d_rt != 5'd0 && d_tuse_rt != TUSE_NONE)
         haz_rt = (e_dst == d_rt && e_tnew > d_tuse_rt) ||
                  (m_dst == d_rt && m_tnew > d_tuse_rt);
   end

`ifdef HAZARD_MD_STALL_EN
   // Mult/div instructions wait in D until the unit is idle.
   always_comb begin
      md_stall = d_is_md && (md_busy || md_start_e);
   end
`else
   // Mult/div serialisation is handled inside the unit; inputs are don't-care.
   logic unused_md;
   always_comb begin
      md_stall  = 1'b0;
      unused_md = d_is_md ^ md_busy ^ md_start_e;
   end
`endif

   // Stall combines data and mult/div hazards.
   always_comb begin
      stall = haz_rs || haz_rt || md_stall;
   end

   // D-stage compare-mux selects; W is covered by the register-file bypass.
   always_comb begin
      fwd_rs_d = 2'b00;
      fwd_rt_d = 2'b00;
      if (d_rs != 5'd0) begin
         if (e_dst == d_rs && e_tnew == '0)      fwd_rs_d = 2'b01;
         else if (m_dst == d_rs && m_tnew == '0) fwd_rs_d = 2'b10;
      end
      if (d_rt != 5'd0) begin
         if (e_dst == d_rt && e_tnew == '0)      fwd_rt_d = 2'b01;
         else if (m_dst == d_rt && m_tnew == '0) fwd_rt_d = 2'b10;
      end
   end

   // E-stage ALU operand selects; the newest matching stage wins.
   always_comb begin
      fwd_rs_e = 2'b00;
      fwd_rt_e = 2'b00;
      if (e_rs != 5'd0) begin
         if (m_dst == e_rs && m_tnew == '0) fwd_rs_e = 2'b01;
         else if (w_dst == e_rs)            fwd_rs_e = 2'b10;
      end
      if (e_rt != 5'd0) begin
         if (m_dst == e_rt && m_tnew == '0) fwd_rt_e = 2'b01;
         else if (w_dst == e_rt)            fwd_rt_e = 2'b10;
      end
   end

endmodule
